// File: rtl/syn_lb_dec_pkg.sv
// syn_lb_dec_pkg: shared types and helpers for the parametrised local-bus decoder.
// Holds the FSM state encoding, the error-reason encoding used by the optional
// statistics counters, and the block-code width derivation.
package syn_lb_dec_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lb_dec_st_t;

    // Why a response carries an error (ERR_NONE for a normal completion)
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_UNMAP = 2'd1,
        ERR_TOUT  = 2'd2,
        ERR_DUAL  = 2'd3
    } lb_err_rsn_t;

    // Width of the statistics counters
    localparam int STAT_W = 16;

    // Block code occupies the address bits above the slave offset
    function automatic int code_w(input int lb_addr_w, input int slv_addr_w);
        return lb_addr_w - slv_addr_w;
    endfunction

endpackage

// File: rtl/syn_lb_dec_wdog.sv
// syn_lb_wdog: WAIT-state watchdog for the local-bus decoder.
// The timer is cleared while the strobe is issued and counts every WAIT cycle;
// expire_o flags the WAIT cycle in which the count reaches P_TIMEOUT.
module syn_lb_wdog #(
    parameter int P_TIMEOUT = 255
) (
    input  logic clk_ir,
    input  logic rst_il,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int TW = $clog2(P_TIMEOUT + 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Next timer value: clear wins over count
    always_comb begin
        timer_d = timer_q;
        if (clr_i) begin
            timer_d = '0;
        end else if (en_i) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Timer register with synchronous active-low reset
    always_ff @(posedge clk_ir) begin
        if (!rst_il) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // This WAIT cycle is the one that brings the count up to P_TIMEOUT
    assign expire_o = en_i && (timer_q == TW'(P_TIMEOUT - 1));

endmodule

// File: rtl/syn_lb_dec_n.sv
// syn_lb_dec_n: registered, parametrised local-bus decoder.
// Splits lb_addr into a block code (upper bits) and a slave offset, strobes the
// selected slave, waits for its matching ack or a watchdog timeout, and returns
// a single response pulse. Unmapped codes, simultaneous wr/rd requests and
// timeouts answer with lb_err=1 (reads return P_ERR_DATA).
// Optional build macro SYN_LB_DEC_STATS_EN adds saturating timeout and
// unmapped/dual-strobe error counters (stat_tout_cnt, stat_unmap_cnt).
module syn_lb_dec_n
    import syn_lb_dec_pkg::*;
#(
    parameter int                     P_LB_DATA_W  = 32,
    parameter int                     P_LB_ADDR_W  = 12,
    parameter int                     P_SLV_ADDR_W = 8,
    parameter int                     P_NUM_SLV    = 4,
    parameter int                     P_TIMEOUT    = 255,
    parameter logic [P_LB_DATA_W-1:0] P_ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                             clk_ir,
    input  logic                             rst_il,
    input  logic                             lb_wr_en,
    input  logic                             lb_rd_en,
    input  logic [P_LB_ADDR_W-1:0]           lb_addr,
    input  logic [P_LB_DATA_W-1:0]           lb_wr_data,
    output logic                             lb_wr_valid,
    output logic                             lb_rd_valid,
    output logic [P_LB_DATA_W-1:0]           lb_rd_data,
    output logic                             lb_err,
    output logic                             lb_busy,
    output logic [P_NUM_SLV-1:0]             slv_wr_en,
    output logic [P_NUM_SLV-1:0]             slv_rd_en,
    output logic [P_SLV_ADDR_W-1:0]          slv_addr,
    output logic [P_LB_DATA_W-1:0]           slv_wr_data,
    input  logic [P_NUM_SLV-1:0]             slv_wr_valid,
    input  logic [P_NUM_SLV-1:0]             slv_rd_valid,
    input  logic [P_NUM_SLV*P_LB_DATA_W-1:0] slv_rd_data
`ifdef SYN_LB_DEC_STATS_EN
    ,
    output logic [STAT_W-1:0]                stat_tout_cnt,
    output logic [STAT_W-1:0]                stat_unmap_cnt
`endif
);

    localparam int P_CODE_W = code_w(P_LB_ADDR_W, P_SLV_ADDR_W);

    lb_dec_st_t              state_q;
    logic                    type_q;      // 1 = read, 0 = write
    logic [P_CODE_W-1:0]     code_q;
    logic [P_SLV_ADDR_W-1:0] addr_q;
    logic [P_LB_DATA_W-1:0]  wdata_q;
    logic [P_NUM_SLV-1:0]    slv_wr_en_q;
    logic [P_NUM_SLV-1:0]    slv_rd_en_q;
    logic                    wr_valid_q;
    logic                    rd_valid_q;
    logic [P_LB_DATA_W-1:0]  rd_data_q;
    logic                    err_q;
    logic                    busy_q;

    logic [P_CODE_W-1:0]     req_code;
    logic                    req_one;
    logic                    req_dual;
    logic                    req_unmap;
    logic [P_NUM_SLV-1:0]    req_oh;
    logic                    slv_ack;
    logic [P_LB_DATA_W-1:0]  rd_sel;
    logic                    tout_exp;

    assign req_code  = lb_addr[P_LB_ADDR_W-1 -: P_CODE_W];
    assign req_one   = lb_wr_en ^ lb_rd_en;
    assign req_dual  = lb_wr_en & lb_rd_en;
    assign req_unmap = (32'(req_code) >= 32'(P_NUM_SLV));

    // Decode the incoming code to a strobe mask and pick the latched slave's ack/data
    always_comb begin
        req_oh  = '0;
        slv_ack = 1'b0;
        rd_sel  = '0;
        for (int i = 0; i < P_NUM_SLV; i++) begin
            if (req_code == P_CODE_W'(i)) begin
                req_oh[i] = 1'b1;
            end
            if (code_q == P_CODE_W'(i)) begin
                slv_ack = type_q ? slv_rd_valid[i] : slv_wr_valid[i];
                rd_sel  = slv_rd_data[i*P_LB_DATA_W +: P_LB_DATA_W];
            end
        end
    end

    syn_lb_wdog #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_wdog (
        .clk_ir   (clk_ir),
        .rst_il   (rst_il),
        .clr_i    (state_q == ISSUE),
        .en_i     (state_q == WAIT),
        .expire_o (tout_exp)
    );

    // Transaction sequencer: capture request, strobe slave, await ack or timeout, pulse response
    always_ff @(posedge clk_ir) begin
        if (!rst_il) begin
            state_q     <= IDLE;
            type_q      <= 1'b0;
            code_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            slv_wr_en_q <= '0;
            slv_rd_en_q <= '0;
            wr_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            slv_wr_en_q <= '0;
            slv_rd_en_q <= '0;
            wr_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_dual) begin
                        // Ambiguous request: answer as an errored read, touch no slave
                        type_q     <= 1'b1;
                        rd_valid_q <= 1'b1;
                        err_q      <= 1'b1;
                        rd_data_q  <= P_ERR_DATA;
                        busy_q     <= 1'b1;
                        state_q    <= RESP;
                    end else if (req_one) begin
                        type_q  <= lb_rd_en;
                        code_q  <= req_code;
                        addr_q  <= lb_addr[P_SLV_ADDR_W-1:0];
                        wdata_q <= lb_wr_data;
                        busy_q  <= 1'b1;
                        if (req_unmap) begin
                            wr_valid_q <= lb_wr_en;
                            rd_valid_q <= lb_rd_en;
                            err_q      <= 1'b1;
                            if (lb_rd_en) begin
                                rd_data_q <= P_ERR_DATA;
                            end
                            state_q <= RESP;
                        end else begin
                            if (lb_rd_en) begin
                                slv_rd_en_q <= req_oh;
                            end else begin
                                slv_wr_en_q <= req_oh;
                            end
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // An ack in the expiring cycle still counts as a good completion
                    if (slv_ack) begin
                        wr_valid_q <= ~type_q;
                        rd_valid_q <= type_q;
                        if (type_q) begin
                            rd_data_q <= rd_sel;
                        end
                        state_q <= RESP;
                    end else if (tout_exp) begin
                        wr_valid_q <= ~type_q;
                        rd_valid_q <= type_q;
                        err_q      <= 1'b1;
                        if (type_q) begin
                            rd_data_q <= P_ERR_DATA;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lb_wr_valid = wr_valid_q;
    assign lb_rd_valid = rd_valid_q;
    assign lb_rd_data  = rd_data_q;
    assign lb_err      = err_q;
    assign lb_busy     = busy_q;
    assign slv_wr_en   = slv_wr_en_q;
    assign slv_rd_en   = slv_rd_en_q;
    assign slv_addr    = addr_q;
    assign slv_wr_data = wdata_q;

`ifdef SYN_LB_DEC_STATS_EN
    lb_err_rsn_t       err_rsn_d;
    lb_err_rsn_t       err_rsn_q;
    logic [STAT_W-1:0] tout_cnt_q;
    logic [STAT_W-1:0] unmap_cnt_q;

    // Classify the error that the upcoming RESP cycle will report
    always_comb begin
        err_rsn_d = ERR_NONE;
        if (state_q == IDLE) begin
            if (req_dual) begin
                err_rsn_d = ERR_DUAL;
            end else if (req_one && req_unmap) begin
                err_rsn_d = ERR_UNMAP;
            end
        end else if (state_q == WAIT) begin
            if (!slv_ack && tout_exp) begin
                err_rsn_d = ERR_TOUT;
            end
        end
    end

    // Saturating error counters, bumped once per errored RESP cycle
    always_ff @(posedge clk_ir) begin
        if (!rst_il) begin
            err_rsn_q   <= ERR_NONE;
            tout_cnt_q  <= '0;
            unmap_cnt_q <= '0;
        end else begin
            err_rsn_q <= err_rsn_d;
            if (state_q == RESP) begin
                if (err_rsn_q == ERR_TOUT && tout_cnt_q != '1) begin
                    tout_cnt_q <= tout_cnt_q + 1'b1;
                end
                if ((err_rsn_q == ERR_UNMAP || err_rsn_q == ERR_DUAL) && unmap_cnt_q != '1) begin
                    unmap_cnt_q <= unmap_cnt_q + 1'b1;
                end
            end
        end
    end

    assign stat_tout_cnt  = tout_cnt_q;
    assign stat_unmap_cnt = unmap_cnt_q;
`endif

endmodule

// File: tb/tb_syn_lb_dec_n.sv
// tb_syn_lb_dec_n: self-checking bench for syn_lb_dec_n (4 slaves, timeout 8).
// A driver task plays the master and the slaves for one transaction and records
// what the DUT did; scenario tasks compare the record against a spec-level model.
module tb_syn_lb_dec_n;

    localparam int NS   = 4;
    localparam int TOUT = 8;
    localparam int WIN  = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic          clk_ir = 1'b0;
    logic          rst_il = 1'b0;
    logic          lb_wr_en = 1'b0;
    logic          lb_rd_en = 1'b0;
    logic [11:0]   lb_addr = '0;
    logic [31:0]   lb_wr_data = '0;
    logic          lb_wr_valid;
    logic          lb_rd_valid;
    logic [31:0]   lb_rd_data;
    logic          lb_err;
    logic          lb_busy;
    logic [NS-1:0] slv_wr_en;
    logic [NS-1:0] slv_rd_en;
    logic [7:0]    slv_addr;
    logic [31:0]   slv_wr_data;
    logic [NS-1:0] slv_wr_valid = '0;
    logic [NS-1:0] slv_rd_valid = '0;
    logic [NS*32-1:0] slv_rd_data = '0;
`ifdef SYN_LB_DEC_STATS_EN
    logic [15:0]   stat_tout_cnt;
    logic [15:0]   stat_unmap_cnt;
`endif

    syn_lb_dec_n #(
        .P_LB_DATA_W (32),
        .P_LB_ADDR_W (12),
        .P_SLV_ADDR_W(8),
        .P_NUM_SLV   (NS),
        .P_TIMEOUT   (TOUT),
        .P_ERR_DATA  (ERRD)
    ) dut (
        .clk_ir      (clk_ir),
        .rst_il      (rst_il),
        .lb_wr_en    (lb_wr_en),
        .lb_rd_en    (lb_rd_en),
        .lb_addr     (lb_addr),
        .lb_wr_data  (lb_wr_data),
        .lb_wr_valid (lb_wr_valid),
        .lb_rd_valid (lb_rd_valid),
        .lb_rd_data  (lb_rd_data),
        .lb_err      (lb_err),
        .lb_busy     (lb_busy),
        .slv_wr_en   (slv_wr_en),
        .slv_rd_en   (slv_rd_en),
        .slv_addr    (slv_addr),
        .slv_wr_data (slv_wr_data),
        .slv_wr_valid(slv_wr_valid),
        .slv_rd_valid(slv_rd_valid),
        .slv_rd_data (slv_rd_data)
`ifdef SYN_LB_DEC_STATS_EN
        ,
        .stat_tout_cnt (stat_tout_cnt),
        .stat_unmap_cnt(stat_unmap_cnt)
`endif
    );

    always #5 clk_ir = ~clk_ir;

    int checks = 0;
    int failures = 0;

    // Observations of the last transaction
    int          ob_lat;
    int          ob_nvalid;
    int          ob_nstrobe;
    logic        ob_wv, ob_rv, ob_err, ob_busy1, ob_busy_end;
    logic [31:0] ob_data;
    logic [3:0]  ob_wen, ob_ren;
    logic [7:0]  ob_saddr;
    logic [31:0] ob_swd;

    task automatic tick();
        @(posedge clk_ir);
        #1;
    endtask

    // Spec model: cycles from the request cycle to the response pulse
    function automatic int exp_lat(bit wr, bit rd, int sel, int k);
        if (wr && rd) return 1;
        if (sel >= NS) return 1;
        if (k >= 1 && k <= TOUT) return 2 + k;
        return 2 + TOUT;
    endfunction

    // Spec model: response carries an error
    function automatic bit exp_err(bit wr, bit rd, int sel, int k);
        return (wr && rd) || (sel >= NS) || !(k >= 1 && k <= TOUT);
    endfunction

    // Master issues one request; the selected slave acks in WAIT cycle k (0 = never).
    // noise: every other slave, and the selected slave with the wrong type, acks each cycle.
    // drop: a second request is presented while the first is still in flight.
    task automatic run_txn(input bit wr, input bit rd, input logic [11:0] addr,
                           input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                           input bit noise, input bit drop);
        int sel;
        sel = int'(addr[11:8]);
        ob_lat = -1; ob_nvalid = 0; ob_nstrobe = 0;
        ob_wv = 0; ob_rv = 0; ob_err = 0; ob_data = '0;
        lb_wr_en = wr; lb_rd_en = rd; lb_addr = addr; lb_wr_data = wdata;
        tick();
        lb_wr_en = 0; lb_rd_en = 0; lb_addr = 12'($urandom); lb_wr_data = $urandom;
        for (int c = 1; c <= WIN; c++) begin
            if (c == 1) begin
                ob_wen = slv_wr_en; ob_ren = slv_rd_en; ob_saddr = slv_addr;
                ob_swd = slv_wr_data; ob_busy1 = lb_busy;
            end
            if (|slv_wr_en || |slv_rd_en) ob_nstrobe++;
            if (lb_wr_valid || lb_rd_valid) begin
                ob_nvalid++;
                if (ob_lat < 0) begin
                    ob_lat = c; ob_wv = lb_wr_valid; ob_rv = lb_rd_valid;
                    ob_err = lb_err; ob_data = lb_rd_data;
                end
            end
            slv_wr_valid = '0; slv_rd_valid = '0;
            slv_rd_data = {$urandom, $urandom, $urandom, $urandom};
            if (noise && c >= 2) begin
                for (int i = 0; i < NS; i++) begin
                    if (i != sel) begin
                        slv_wr_valid[i] = 1'b1; slv_rd_valid[i] = 1'b1;
                    end else if (rd) begin
                        slv_wr_valid[i] = 1'b1;
                    end else begin
                        slv_rd_valid[i] = 1'b1;
                    end
                end
            end
            if (k > 0 && c == 1 + k && sel < NS) begin
                if (rd) slv_rd_valid[sel] = 1'b1;
                else    slv_wr_valid[sel] = 1'b1;
                slv_rd_data[sel*32 +: 32] = rdata;
            end
            if (drop && c == 2) begin
                lb_wr_en = 1'b1; lb_addr = 12'h0AA;
            end else begin
                lb_wr_en = 1'b0;
            end
            tick();
        end
        slv_wr_valid = '0; slv_rd_valid = '0;
        ob_busy_end = lb_busy;
    endtask

    task automatic test_reset();
        rst_il = 1'b0;
        tick(); tick(); tick();
        checks++; if (lb_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", lb_busy); end
        checks++; if ({lb_wr_valid, lb_rd_valid, lb_err} !== 3'b000) begin failures++; $display("FAIL reset_valid_err: got %b want 000", {lb_wr_valid, lb_rd_valid, lb_err}); end
        checks++; if (lb_rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h want 0", lb_rd_data); end
        checks++; if ({slv_wr_en, slv_rd_en} !== 8'h00) begin failures++; $display("FAIL reset_strobes: got %b want 0", {slv_wr_en, slv_rd_en}); end
        checks++; if ({slv_addr, slv_wr_data} !== 40'h0) begin failures++; $display("FAIL reset_slv_bus: got %h want 0", {slv_addr, slv_wr_data}); end
`ifdef SYN_LB_DEC_STATS_EN
        checks++; if ({stat_tout_cnt, stat_unmap_cnt} !== 32'h0) begin failures++; $display("FAIL reset_stats: got %h want 0", {stat_tout_cnt, stat_unmap_cnt}); end
`endif
        rst_il = 1'b1;
        tick();
    endtask

    task automatic test_write_ack();
        run_txn(1, 0, 12'h123, 32'hA5A5_0001, 2, 32'h0, 0, 0);
        checks++; if (ob_wen !== 4'b0010 || ob_ren !== 4'b0000) begin failures++; $display("FAIL wr_strobe: got wr=%b rd=%b want wr=0010 rd=0000", ob_wen, ob_ren); end
        checks++; if (ob_saddr !== 8'h23) begin failures++; $display("FAIL wr_slv_addr: got %h want 23", ob_saddr); end
        checks++; if (ob_swd !== 32'hA5A5_0001) begin failures++; $display("FAIL wr_slv_data: got %h want a5a50001", ob_swd); end
        checks++; if (ob_busy1 !== 1'b1) begin failures++; $display("FAIL wr_busy: got %b want 1", ob_busy1); end
        checks++; if (ob_lat !== 4) begin failures++; $display("FAIL wr_latency: got %0d want 4", ob_lat); end
        checks++; if ({ob_wv, ob_rv, ob_err} !== 3'b100) begin failures++; $display("FAIL wr_resp: got wv/rv/err=%b want 100", {ob_wv, ob_rv, ob_err}); end
        checks++; if (ob_busy_end !== 1'b0) begin failures++; $display("FAIL wr_busy_end: got %b want 0", ob_busy_end); end
    endtask

    task automatic test_read_first_wait();
        run_txn(0, 1, 12'h3FF, 32'h0, 1, 32'hCAFE_F00D, 0, 0);
        checks++; if (ob_ren !== 4'b1000 || ob_wen !== 4'b0000) begin failures++; $display("FAIL rd_strobe: got rd=%b wr=%b want rd=1000 wr=0000", ob_ren, ob_wen); end
        checks++; if (ob_lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d want 3", ob_lat); end
        checks++; if ({ob_wv, ob_rv, ob_err} !== 3'b010) begin failures++; $display("FAIL rd_resp: got wv/rv/err=%b want 010", {ob_wv, ob_rv, ob_err}); end
        checks++; if (ob_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL rd_data: got %h want cafef00d", ob_data); end
    endtask

    task automatic test_unmapped();
`ifdef SYN_LB_DEC_STATS_EN
        logic [15:0] pre;
        pre = stat_unmap_cnt;
`endif
        run_txn(0, 1, 12'h5A7, 32'h0, 1, 32'h1234_5678, 0, 0);
        checks++; if (ob_nstrobe !== 0) begin failures++; $display("FAIL unmap_strobe: got %0d strobes want 0", ob_nstrobe); end
        checks++; if (ob_lat !== 1) begin failures++; $display("FAIL unmap_latency: got %0d want 1", ob_lat); end
        checks++; if ({ob_rv, ob_err} !== 2'b11 || ob_data !== ERRD) begin failures++; $display("FAIL unmap_resp: got rv/err=%b data=%h want 11 deadbeef", {ob_rv, ob_err}, ob_data); end
        checks++; if (ob_nvalid !== 1) begin failures++; $display("FAIL unmap_nvalid: got %0d want 1", ob_nvalid); end
`ifdef SYN_LB_DEC_STATS_EN
        checks++; if (stat_unmap_cnt !== pre + 16'd1) begin failures++; $display("FAIL unmap_stat: got %0d want %0d", stat_unmap_cnt, pre + 16'd1); end
`endif
    endtask

    task automatic test_timeout();
`ifdef SYN_LB_DEC_STATS_EN
        logic [15:0] pre;
        pre = stat_tout_cnt;
`endif
        // Other slaves and wrong-type acks every cycle, real ack only after the response
        run_txn(0, 1, 12'h240, 32'h0, TOUT + 3, 32'h0BAD_0BAD, 1, 0);
        checks++; if (ob_lat !== 2 + TOUT) begin failures++; $display("FAIL tout_latency: got %0d want %0d", ob_lat, 2 + TOUT); end
        checks++; if ({ob_rv, ob_err} !== 2'b11 || ob_data !== ERRD) begin failures++; $display("FAIL tout_resp: got rv/err=%b data=%h want 11 deadbeef", {ob_rv, ob_err}, ob_data); end
        checks++; if (ob_nvalid !== 1) begin failures++; $display("FAIL tout_late_ack: got %0d valids want 1", ob_nvalid); end
`ifdef SYN_LB_DEC_STATS_EN
        checks++; if (stat_tout_cnt !== pre + 16'd1) begin failures++; $display("FAIL tout_stat: got %0d want %0d", stat_tout_cnt, pre + 16'd1); end
`endif
    endtask

    task automatic test_timeout_edge();
        run_txn(1, 0, 12'h3C0, 32'h7777_0000, TOUT, 32'h0, 1, 0);
        checks++; if (ob_lat !== 2 + TOUT || {ob_wv, ob_err} !== 2'b10) begin failures++; $display("FAIL edge_ack_wins: got lat=%0d wv/err=%b want %0d 10", ob_lat, {ob_wv, ob_err}, 2 + TOUT); end
        run_txn(0, 1, 12'h011, 32'h0, TOUT + 1, 32'h5555_AAAA, 0, 0);
        checks++; if (ob_lat !== 2 + TOUT || {ob_rv, ob_err} !== 2'b11 || ob_data !== ERRD) begin failures++; $display("FAIL edge_too_late: got lat=%0d rv/err=%b data=%h want %0d 11 deadbeef", ob_lat, {ob_rv, ob_err}, ob_data, 2 + TOUT); end
    endtask

    task automatic test_dual_and_busy_drop();
        run_txn(1, 1, 12'h155, 32'h1, 1, 32'h0, 0, 0);
        checks++; if (ob_nstrobe !== 0) begin failures++; $display("FAIL dual_strobe: got %0d strobes want 0", ob_nstrobe); end
        checks++; if (ob_lat !== 1 || {ob_wv, ob_rv, ob_err} !== 3'b011 || ob_data !== ERRD) begin failures++; $display("FAIL dual_resp: got lat=%0d wv/rv/err=%b data=%h want 1 011 deadbeef", ob_lat, {ob_wv, ob_rv, ob_err}, ob_data); end
        run_txn(0, 1, 12'h155, 32'h0, 3, 32'h600D_D00D, 0, 1);
        checks++; if (ob_nstrobe !== 1 || ob_nvalid !== 1) begin failures++; $display("FAIL busy_drop: got strobes=%0d valids=%0d want 1 1", ob_nstrobe, ob_nvalid); end
        checks++; if (ob_lat !== 5 || ob_data !== 32'h600D_D00D || ob_err !== 1'b0) begin failures++; $display("FAIL busy_drop_resp: got lat=%0d data=%h err=%b want 5 600dd00d 0", ob_lat, ob_data, ob_err); end
        checks++; if (ob_busy_end !== 1'b0) begin failures++; $display("FAIL busy_drop_idle: got busy=%b want 0", ob_busy_end); end
    endtask

    task automatic test_reset_mid_wait();
        int nv;
        nv = 0;
        lb_rd_en = 1'b1; lb_addr = 12'h110; lb_wr_data = 32'h0;
        tick();
        lb_rd_en = 1'b0;
        tick();
        rst_il = 1'b0;
        tick();
        rst_il = 1'b1;
        checks++; if ({lb_busy, lb_wr_valid, lb_rd_valid, lb_err} !== 4'b0000) begin failures++; $display("FAIL midrst_ctrl: got %b want 0000", {lb_busy, lb_wr_valid, lb_rd_valid, lb_err}); end
        checks++; if ({slv_wr_en, slv_rd_en} !== 8'h0 || slv_addr !== 8'h0 || lb_rd_data !== 32'h0) begin failures++; $display("FAIL midrst_bus: got en=%h addr=%h rdata=%h want 0", {slv_wr_en, slv_rd_en}, slv_addr, lb_rd_data); end
        for (int c = 0; c < 12; c++) begin
            slv_rd_valid = (c < 3) ? 4'b0010 : 4'b0000;
            slv_rd_data  = {4{32'h1111_2222}};
            tick();
            if (lb_wr_valid || lb_rd_valid) nv++;
        end
        slv_rd_valid = '0;
        checks++; if (nv !== 0) begin failures++; $display("FAIL midrst_late_ack: got %0d valids want 0", nv); end
    endtask

    task automatic test_random();
        bit wr, rd;
        int sel, k, el;
        bit ee, noise;
        logic [11:0] addr;
        logic [31:0] wd, rdv;
        logic [3:0] oh;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 6);
            addr = {4'(sel), 8'($urandom)};
            rd = $urandom_range(0, 1);
            wr = ($urandom_range(0, 9) == 0) ? 1'b1 : ~rd;
            k = $urandom_range(0, 12);
            noise = $urandom_range(0, 1);
            wd = $urandom; rdv = $urandom;
            run_txn(wr, rd, addr, wd, k, rdv, noise, 0);
            el = exp_lat(wr, rd, sel, k);
            ee = exp_err(wr, rd, sel, k);
            oh = (sel < NS && !(wr && rd)) ? (4'b0001 << sel) : 4'b0000;
            checks++; if (ob_lat !== el || ob_err !== ee) begin failures++; $display("FAIL rnd%0d_lat_err: got lat=%0d err=%b want %0d %b (addr=%h wr=%b rd=%b k=%0d)", n, ob_lat, ob_err, el, ee, addr, wr, rd, k); end
            checks++; if (ob_rv !== rd || ob_wv !== (wr && !rd) || ob_nvalid !== 1) begin failures++; $display("FAIL rnd%0d_valid: got wv=%b rv=%b n=%0d want %b %b 1", n, ob_wv, ob_rv, ob_nvalid, wr && !rd, rd); end
            if (rd) begin
                checks++; if (ob_data !== (ee ? ERRD : rdv)) begin failures++; $display("FAIL rnd%0d_data: got %h want %h", n, ob_data, ee ? ERRD : rdv); end
            end
            checks++; if (ob_wen !== (rd ? 4'b0 : oh) || ob_ren !== (rd ? oh : 4'b0) || ob_nstrobe !== ((oh != 0) ? 1 : 0)) begin failures++; $display("FAIL rnd%0d_strobe: got wr=%b rd=%b n=%0d want oh=%b", n, ob_wen, ob_ren, ob_nstrobe, oh); end
            if (oh != 0) begin
                checks++; if (ob_saddr !== addr[7:0] || (!rd && ob_swd !== wd)) begin failures++; $display("FAIL rnd%0d_slv_bus: got addr=%h wd=%h want %h %h", n, ob_saddr, ob_swd, addr[7:0], wd); end
            end
            checks++; if (ob_busy_end !== 1'b0) begin failures++; $display("FAIL rnd%0d_busy_end: got %b want 0", n, ob_busy_end); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_write_ack();
        test_read_first_wait();
        test_unmapped();
        test_timeout();
        test_timeout_edge();
        test_dual_and_busy_drop();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/syn_lb_dec_n.md
Name: syn_lb_dec_n

Overview:
- Parametrised, registered local-bus decoder; successor to the fixed 4-way ACORTEX combinational decoder.
- Splits the LB address into a block code and a slave offset, and routes one transaction at a time to one of P_NUM_SLV slaves.
- Tracks the transaction until the selected slave responds. Unmapped codes and slave timeouts return an error response, so the master never hangs.
- Sits between the top-level LB master and any cortex (ACORTEX, VCORTEX, ...).

Parameters:
- P_LB_DATA_W, 32, LB data width.
- P_LB_ADDR_W, 12, LB address width.
- P_SLV_ADDR_W, 8, slave offset width; block code width P_CODE_W = P_LB_ADDR_W - P_SLV_ADDR_W.
- P_NUM_SLV, 4, number of slaves, 1..2^P_CODE_W.
- P_TIMEOUT, 255, max WAIT cycles before error; must be >= 1.
- P_ERR_DATA, 32'hDEAD_BEEF, rd_data returned on an error read.

Ports:
- clk_ir  in  1  clock.
- rst_il  in  1  reset; synchronous, active-low.
- lb_wr_en  in  1  write request pulse.
- lb_rd_en  in  1  read request pulse.
- lb_addr  in  P_LB_ADDR_W  address.
- lb_wr_data  in  P_LB_DATA_W  write data.
- lb_wr_valid  out  1  write complete pulse.
- lb_rd_valid  out  1  read complete pulse.
- lb_rd_data  out  P_LB_DATA_W  read data, valid with lb_rd_valid.
- lb_err  out  1  error flag, valid with either valid pulse.
- lb_busy  out  1  transaction in flight.
- slv_wr_en  out  P_NUM_SLV  one-hot write strobe.
- slv_rd_en  out  P_NUM_SLV  one-hot read strobe.
- slv_addr  out  P_SLV_ADDR_W  offset.
- slv_wr_data  out  P_LB_DATA_W  write data.
- slv_wr_valid  in  P_NUM_SLV  per-slave write ack.
- slv_rd_valid  in  P_NUM_SLV  per-slave read ack.
- slv_rd_data  in  P_NUM_SLV*P_LB_DATA_W  packed; slave i occupies [i*P_LB_DATA_W +: P_LB_DATA_W].

Behaviour:
- Reset (rst_il=0 at posedge): state IDLE; all outputs 0; latched addr/data/code/type 0; timer 0.
- Reset mid-transaction aborts it: no valid pulse is issued; any later slave valid is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, wr_en xor rd_en:
  - Latch code = lb_addr[MSB -: P_CODE_W], offset, wr_data and type.
  - If code >= P_NUM_SLV, go to RESP with err=1.
  - Otherwise go to ISSUE.
- IDLE, wr_en and rd_en together: go to RESP with err=1 and type=read; no slave access.
- ISSUE (1 cycle):
  - slv_wr_en[code] or slv_rd_en[code] = 1.
  - slv_addr and slv_wr_data are driven from the latches and held stable through WAIT.
  - Timer cleared. Go to WAIT.
- WAIT:
  - Only the valid of the selected slave, for the matching type, is accepted. All others are ignored, including a write ack during a read.
  - On accept: capture rd_data slice (reads), err=0, go to RESP.
  - Otherwise the timer increments. When the timer reaches P_TIMEOUT, go to RESP with err=1, rd_data=P_ERR_DATA.
  - Acceptance in the same cycle as the timeout wins: err=0.
- RESP (1 cycle): pulse lb_wr_valid or lb_rd_valid plus lb_err; then IDLE.
- Error read returns rd_data=P_ERR_DATA. Error write returns lb_wr_valid with err=1.
- lb_busy = (state != IDLE). Requests seen while busy are dropped with no response; the master must wait for valid.
- Minimum latency from request cycle to valid pulse: 3 cycles for mapped access with a slave acking in the first WAIT cycle; 1 cycle for an unmapped access.
- All outputs are registered. slv_*_en are single-cycle pulses.

Optional Feature:
- SYN_LB_DEC_STATS_EN defined:
  - Adds outputs stat_tout_cnt[15:0] and stat_unmap_cnt[15:0], saturating at 16'hFFFF, cleared by reset.
  - They increment on the RESP cycle of a timeout or of an unmapped/dual-strobe error respectively.
- Undefined: ports absent, no counter logic.

Decomposition:
- syn_lb_dec_pkg holds:
  - state enum lb_dec_st_t {IDLE, ISSUE, WAIT, RESP};
  - P_CODE_W derivation helper;
  - error-reason enum {ERR_NONE, ERR_UNMAP, ERR_TOUT, ERR_DUAL} used by the stats logic.
- Sub-module syn_lb_wdog holds the timeout counter (clear, enable, P_TIMEOUT compare, expire pulse).

Test Plan:
- P_NUM_SLV=4. Write 0x123 data 0xA5A5_0001; slave 1 acks 2 cycles after its strobe -> slv_wr_en=4'b0010, slv_addr=0x23, lb_wr_valid with err=0 exactly 1 cycle after the ack.
- Read 0x3FF; slave 3 returns 0xCAFE_F00D in the first WAIT cycle -> lb_rd_data=0xCAFE_F00D, err=0, valid 3 cycles after the request.
- Read 0x5xx (code 5 >= 4) -> no slv strobe; lb_rd_valid with err=1 and rd_data=0xDEAD_BEEF on the next cycle; with SYN_LB_DEC_STATS_EN, stat_unmap_cnt=1.
- Read slave 2, never acked, P_TIMEOUT=8 -> lb_rd_valid with err=1 after 8 WAIT cycles; slave 0 rd_valid pulsed during WAIT is ignored; a late slave 2 ack after RESP produces no second valid.
- Simultaneous wr_en and rd_en -> rd_valid with err=1, no slave strobes. A new request during busy -> dropped, no extra valid.
- Assert rst_il=0 during WAIT -> all outputs 0 the next cycle; a slave ack after release produces no valid.
